// File: rtl/clock_reset_sequencer.sv
// Staged reset sequencer behind the SoC PLL: debounces lock, releases peripheral
// reset first and CPU reset HOLD_CYCLES later, and counts lock losses.
module clock_reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CYCLES = 1024,
    parameter int HOLD_CYCLES = 16,
    parameter int LOSS_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pll_locked,
    output logic                  periph_resetn,
    output logic                  cpu_resetn,
    output logic                  sys_reset,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    localparam int MAX_CYCLES = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0]      LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [LOSS_CNT_W-1:0] LOSS_MAX  = {LOSS_CNT_W{1'b1}};
    localparam logic [LOSS_CNT_W-1:0] LOSS_ONE  = LOSS_CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   locked_s;
    logic                   loss_inc_s;

    assign locked_s = sync_r[SYNC_STAGES-1];

    // Next-state and counter logic; a lock drop takes priority over any terminal count.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        loss_inc_s = 1'b0;
        case (state_r)
            WAIT_LOCK: begin
                cnt_s = CNT_ZERO;
                if (locked_s) begin
                    state_s = STABLE;
                end else begin
                    state_s = WAIT_LOCK;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_s = WAIT_LOCK;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == LOCK_LAST) begin
                    state_s = HOLD;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_s    = WAIT_LOCK;
                    cnt_s      = CNT_ZERO;
                    loss_inc_s = 1'b1;
                end else if (cnt_r == HOLD_LAST) begin
                    state_s = RUN;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            RUN: begin
                cnt_s = CNT_ZERO;
                if (!locked_s) begin
                    state_s    = WAIT_LOCK;
                    loss_inc_s = 1'b1;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = WAIT_LOCK;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, synchroniser, loss counter and registered outputs (decoded from next state).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= WAIT_LOCK;
            cnt_r           <= CNT_ZERO;
            sync_r          <= {SYNC_STAGES{1'b0}};
            periph_resetn   <= 1'b0;
            cpu_resetn      <= 1'b0;
            sys_reset       <= 1'b1;
            ready           <= 1'b0;
            lock_loss_count <= {LOSS_CNT_W{1'b0}};
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            sync_r        <= {sync_r[SYNC_STAGES-2:0], pll_locked};
            periph_resetn <= (state_s == HOLD) || (state_s == RUN);
            cpu_resetn    <= (state_s == RUN);
            sys_reset     <= (state_s != RUN);
            ready         <= (state_s == RUN);
            if (loss_inc_s && (lock_loss_count != LOSS_MAX)) begin
                lock_loss_count <= lock_loss_count + LOSS_ONE;
            end else begin
                lock_loss_count <= lock_loss_count;
            end
        end
    end

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Directed bench for clock_reset_sequencer (SYNC_STAGES=2, LOCK_CYCLES=8, HOLD_CYCLES=4,
// LOSS_CNT_W=2); expected output snapshots are queued with the stimulus and popped on check.
module tb_clock_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       periph_resetn;
    logic       cpu_resetn;
    logic       sys_reset;
    logic       ready;
    logic [1:0] lock_loss_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic       p;
        logic       c;
        logic       r;
        logic [1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    clock_reset_sequencer #(
        .SYNC_STAGES(2),
        .LOCK_CYCLES(8),
        .HOLD_CYCLES(4),
        .LOSS_CNT_W (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pll_locked     (pll_locked),
        .periph_resetn  (periph_resetn),
        .cpu_resetn     (cpu_resetn),
        .sys_reset      (sys_reset),
        .ready          (ready),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check();
        exp_t e;
        e = exp_q.pop_front();
        cmp({e.tag, "_periph"}, {7'd0, periph_resetn}, {7'd0, e.p});
        cmp({e.tag, "_cpu"},    {7'd0, cpu_resetn},    {7'd0, e.c});
        cmp({e.tag, "_sys"},    {7'd0, sys_reset},     {7'd0, ~e.c});
        cmp({e.tag, "_ready"},  {7'd0, ready},         {7'd0, e.r});
        cmp({e.tag, "_loss"},   {6'd0, lock_loss_count}, {6'd0, e.cnt});
        cmp({e.tag, "_inv"},    {7'd0, cpu_resetn & ~periph_resetn}, 8'd0);
    endtask

    // queue the expected snapshot, advance n edges, then compare
    task automatic expect_after(input int n, input string tag, input logic p, input logic c,
                                input logic r, input logic [1:0] cnt);
        exp_t e;
        e.tag = tag;
        e.p   = p;
        e.c   = c;
        e.r   = r;
        e.cnt = cnt;
        exp_q.push_back(e);
        step(n);
        sb_check();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        step(n);
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] sat_exp [5];
        logic [1:0] prev;
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // 1. clean power-up
        pll_locked = 1'b0;
        expect_after(3, "t1_in_reset", 1'b0, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;
        pll_locked = 1'b1;
        expect_after(10, "t1_edge9",  1'b0, 1'b0, 1'b0, 2'd0);
        expect_after(1,  "t1_edge10", 1'b1, 1'b0, 1'b0, 2'd0);
        expect_after(3,  "t1_edge13", 1'b1, 1'b0, 1'b0, 2'd0);
        expect_after(1,  "t1_edge14", 1'b1, 1'b1, 1'b1, 2'd0);

        // 2. one-cycle glitch at edge 5 during STABLE restarts the count
        pll_locked = 1'b0;
        do_reset(2);
        pll_locked = 1'b1;
        step(5);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        expect_after(10, "t2_edge15", 1'b0, 1'b0, 1'b0, 2'd0);
        expect_after(1,  "t2_edge16", 1'b1, 1'b0, 1'b0, 2'd0);
        expect_after(4,  "t2_edge20", 1'b1, 1'b1, 1'b1, 2'd0);

        // 3. lock loss in RUN, then re-lock
        pll_locked = 1'b0;
        do_reset(2);
        pll_locked = 1'b1;
        expect_after(15, "t3_run",   1'b1, 1'b1, 1'b1, 2'd0);
        expect_after(20, "t3_run20", 1'b1, 1'b1, 1'b1, 2'd0);
        pll_locked = 1'b0;
        expect_after(2, "t3_drop_d1", 1'b1, 1'b1, 1'b1, 2'd0);
        expect_after(1, "t3_drop_d2", 1'b0, 1'b0, 1'b0, 2'd1);
        pll_locked = 1'b1;
        expect_after(10, "t3_re_edge9",  1'b0, 1'b0, 1'b0, 2'd1);
        expect_after(1,  "t3_re_edge10", 1'b1, 1'b0, 1'b0, 2'd1);
        expect_after(3,  "t3_re_edge13", 1'b1, 1'b0, 1'b0, 2'd1);
        expect_after(1,  "t3_re_edge14", 1'b1, 1'b1, 1'b1, 2'd1);

        // 4. lock loss in HOLD, coinciding with the HOLD terminal count
        pll_locked = 1'b0;
        do_reset(2);
        pll_locked = 1'b1;
        step(12);
        pll_locked = 1'b0;
        expect_after(2, "t4_edge13", 1'b1, 1'b0, 1'b0, 2'd0);
        expect_after(1, "t4_edge14", 1'b0, 1'b0, 1'b0, 2'd1);
        expect_after(10, "t4_later", 1'b0, 1'b0, 1'b0, 2'd1);

        // 5. loss-counter saturation over five RUN lock losses
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            prev = (i == 0) ? 2'd0 : sat_exp[i-1];
            pll_locked = 1'b1;
            expect_after(15, $sformatf("t5_run%0d", i), 1'b1, 1'b1, 1'b1, prev);
            pll_locked = 1'b0;
            expect_after(3, $sformatf("t5_loss%0d", i), 1'b0, 1'b0, 1'b0, sat_exp[i]);
        end

        // 6. mid-operation reset while in HOLD clears everything and restarts
        pll_locked = 1'b1;
        expect_after(12, "t6_hold", 1'b1, 1'b0, 1'b0, 2'd3);
        reset = 1'b1;
        expect_after(1, "t6_reset", 1'b0, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;
        expect_after(10, "t6_edge9",  1'b0, 1'b0, 1'b0, 2'd0);
        expect_after(1,  "t6_edge10", 1'b1, 1'b0, 1'b0, 2'd0);
        expect_after(3,  "t6_edge13", 1'b1, 1'b0, 1'b0, 2'd0);
        expect_after(1,  "t6_edge14", 1'b1, 1'b1, 1'b1, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
